// File: rtl/reg_wb_ctrl.sv
// Register-file writeback controller: merges ALU and load results into a small FIFO
// that drains one entry per cycle into the register-file write port.
module reg_wb_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_wd,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [31:0]              ld_wd,
  output logic                     we,
  output logic [4:0]               wr,
  output logic [31:0]              wd,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    r_rd [DEPTH];
  logic [31:0]   r_wd [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_push_a;
  logic          w_push_l;
  logic          w_pop;
  logic [PW-1:0] w_ptr_l;
  logic [PW-1:0] w_off;
  logic [31:0]   w_pend;

  // Readiness looks only at registered occupancy; the pop in the same cycle is not credited.
  assign alu_ready = ~rst & (r_count < CW'(DEPTH));
  assign ld_ready  = ~rst & ((r_count < CW'(DEPTH - 1)) |
                             ((r_count == CW'(DEPTH - 1)) & ~alu_valid));

  // Writes to x0 complete the handshake but are never stored.
  assign w_push_a = alu_valid & alu_ready & (alu_rd != 5'd0);
  assign w_push_l = ld_valid & ld_ready & (ld_rd != 5'd0);
  assign w_pop    = (r_count != '0);

  // The load entry lands behind the ALU entry when both push together.
  assign w_ptr_l  = r_wptr + PW'(w_push_a);

  assign we        = w_pop;
  assign wr        = w_pop ? r_rd[r_rptr] : 5'd0;
  assign wd        = w_pop ? r_wd[r_rptr] : 32'd0;
  assign count     = r_count;
  assign pend_mask = w_pend;

  always_comb begin
    w_pend = '0;
    w_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rptr;
      if ({1'b0, w_off} < r_count) w_pend[r_rd[i]] = 1'b1;
    end
    w_pend[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i] <= '0;
        r_wd[i] <= '0;
      end
    end else begin
      if (w_push_a) begin
        r_rd[r_wptr] <= alu_rd;
        r_wd[r_wptr] <= alu_wd;
      end
      if (w_push_l) begin
        r_rd[w_ptr_l] <= ld_rd;
        r_wd[w_ptr_l] <= ld_wd;
      end
      r_wptr  <= r_wptr + PW'(w_push_a) + PW'(w_push_l);
      r_rptr  <= r_rptr + PW'(w_pop);
      r_count <= r_count + CW'(w_push_a) + CW'(w_push_l) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl (DEPTH=4): reset, single/dual push, x0 drop,
// backpressure, pointer wrap and mid-flight reset.
module tb_reg_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid;
  logic        alu_ready, ld_ready;
  logic [4:0]  alu_rd, ld_rd;
  logic [31:0] alu_wd, ld_wd;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [31:0] pend_mask;
  logic [2:0]  count;

  int vectors    = 0;
  int miscompares = 0;

  reg_wb_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_wd(ld_wd),
    .we(we), .wr(wr), .wd(wd), .pend_mask(pend_mask), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_wd = d;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ld_valid = v; ld_rd = rd; ld_wd = d;
  endtask

  initial begin
    rst = 1'b1;
    set_alu(1'b1, 5'd3, 32'h1234);
    set_ld(1'b1, 5'd4, 32'h5678);
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    step();
    step();
    chk("rst_hold_count", 32'(count), 32'd0);
    set_alu(1'b0, 5'd0, 32'd0);
    set_ld(1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_we", 32'(we), 32'd0);
    chk("idle_alu_ready", 32'(alu_ready), 32'd1);

    // Single ALU write
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    chk("single_we", 32'(we), 32'd1);
    chk("single_wr", 32'(wr), 32'd5);
    chk("single_wd", wd, 32'hDEADBEEF);
    chk("single_pend", pend_mask, 32'h20);
    chk("single_count", 32'(count), 32'd1);
    step();
    chk("single_done_count", 32'(count), 32'd0);
    chk("single_done_pend", pend_mask, 32'd0);
    chk("single_done_we", 32'(we), 32'd0);

    // x0 write is dropped
    set_alu(1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    chk("x0_we", 32'(we), 32'd0);
    chk("x0_count", 32'(count), 32'd0);
    chk("x0_pend", pend_mask, 32'd0);

    // Dual push: ALU ahead of load
    set_alu(1'b1, 5'd1, 32'h11);
    set_ld(1'b1, 5'd2, 32'h22);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    set_ld(1'b0, 5'd0, 32'd0);
    chk("dual_count", 32'(count), 32'd2);
    chk("dual_wr0", 32'(wr), 32'd1);
    chk("dual_wd0", wd, 32'h11);
    chk("dual_pend0", pend_mask, 32'h6);
    step();
    chk("dual_count1", 32'(count), 32'd1);
    chk("dual_wr1", 32'(wr), 32'd2);
    chk("dual_wd1", wd, 32'h22);
    chk("dual_pend1", pend_mask, 32'h4);
    step();
    chk("dual_empty_we", 32'(we), 32'd0);

    // Backpressure: build count=3, then both valid
    set_alu(1'b1, 5'd3, 32'h33);
    set_ld(1'b1, 5'd4, 32'h44);
    step();
    set_alu(1'b1, 5'd5, 32'h55);
    set_ld(1'b1, 5'd6, 32'h66);
    chk("bp_ld_ready_at2", 32'(ld_ready), 32'd1);
    step();
    chk("bp_count3", 32'(count), 32'd3);
    chk("bp_head4", 32'(wr), 32'd4);
    set_alu(1'b1, 5'd7, 32'h77);
    set_ld(1'b1, 5'd8, 32'h88);
    #1;
    chk("bp_alu_ready", 32'(alu_ready), 32'd1);
    chk("bp_ld_ready_low", 32'(ld_ready), 32'd0);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    #1;
    chk("bp_count_hold", 32'(count), 32'd3);
    chk("bp_head5", 32'(wr), 32'd5);
    chk("bp_ld_ready_free", 32'(ld_ready), 32'd1);
    step();
    set_ld(1'b0, 5'd0, 32'd0);
    chk("bp_pend", pend_mask, 32'h1C0);
    chk("bp_head6", 32'(wr), 32'd6);
    chk("bp_wd6", wd, 32'h66);
    step();
    chk("bp_head7", 32'(wr), 32'd7);
    chk("bp_wd7", wd, 32'h77);
    step();
    chk("bp_head8", 32'(wr), 32'd8);
    chk("bp_wd8", wd, 32'h88);
    step();
    chk("bp_empty_we", 32'(we), 32'd0);

    // Wrap-around: 10 back-to-back ALU writes
    for (int k = 1; k <= 10; k++) begin
      set_alu(1'b1, 5'(k), 32'h100 + 32'(k));
      step();
      chk("wrap_we", 32'(we), 32'd1);
      chk("wrap_wr", 32'(wr), 32'(k));
      chk("wrap_wd", wd, 32'h100 + 32'(k));
      chk("wrap_count", 32'(count), 32'd1);
    end
    set_alu(1'b0, 5'd0, 32'd0);
    step();
    chk("wrap_empty_we", 32'(we), 32'd0);

    // Reset mid-flight with three entries queued
    set_alu(1'b1, 5'd9, 32'h99);
    set_ld(1'b1, 5'd10, 32'hAA);
    step();
    set_alu(1'b1, 5'd11, 32'hBB);
    set_ld(1'b1, 5'd12, 32'hCC);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    set_ld(1'b0, 5'd0, 32'd0);
    chk("mid_count3", 32'(count), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_pend", pend_mask, 32'd0);
    chk("mid_rst_wr", 32'(wr), 32'd0);
    chk("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_we", 32'(we), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);
    end

    // Normal operation resumes
    set_alu(1'b1, 5'd13, 32'hD0D0);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    chk("resume_wr", 32'(wr), 32'd13);
    chk("resume_wd", wd, 32'hD0D0);
    step();
    chk("resume_empty", 32'(we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the write-queue entry count (power of two, >= 2).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: asynchronous, active-high.
REQ-004 Ports alu_valid (input, 1), alu_ready (output, 1), alu_rd (input, 5), alu_wd (input, 32) SHALL form the ALU result producer channel.
REQ-005 Ports ld_valid (input, 1), ld_ready (output, 1), ld_rd (input, 5), ld_wd (input, 32) SHALL form the load-unit result producer channel.
REQ-006 Ports we (output, 1), wr (output, 5), wd (output, 32) SHALL drive the register-file write port directly.
REQ-007 Port pend_mask, output, 32, SHALL give the per-register pending-write mask for hazard detection.
REQ-008 Port count, output, clog2(DEPTH)+1, SHALL give the current queue occupancy.

Function
REQ-009 Producer transfers SHALL occur on a rising edge where valid and ready are both high; valid with ready low SHALL hold, and producer payload SHALL be ignored otherwise.
REQ-010 alu_ready SHALL be high when count < DEPTH, from registered count only, with no pop lookahead.
REQ-011 ld_ready SHALL be high when count < DEPTH-1, or when count == DEPTH-1 and alu_valid is low.
REQ-012 Accepted transfers with rd != 0 SHALL be enqueued as {rd, wd}.
REQ-013 Accepted transfers with rd == 0 SHALL be consumed without being stored: no count change, no write-port activity.
REQ-014 Simultaneous ALU and load transfers in one cycle SHALL both enqueue, with the ALU entry ahead of the load entry.
REQ-015 The queue SHALL be FIFO-ordered: write-port order equals enqueue order.
REQ-016 wr/wd SHALL show the head entry combinationally; we = (count != 0).
REQ-017 When count != 0, the head SHALL pop on every rising edge (the register file never stalls).
REQ-018 Minimum latency: an entry accepted at edge N SHALL appear on we/wr/wd during cycle N..N+1 and be written at edge N+1.
REQ-019 Each edge, count SHALL update as count + pushes - pop; push and pop in one cycle SHALL both take effect.
REQ-020 count SHALL never exceed DEPTH; with count == DEPTH, both readies SHALL be low.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-022 pend_mask[i] SHALL be 1 iff any valid queue entry has rd == i.
REQ-023 pend_mask SHALL be derived from registered queue state, and pend_mask[0] SHALL be 0 always.
REQ-024 When wr == 0 is impossible (REQ-013), wd SHALL be don't-care while we is low.

Reset
REQ-025 On rst assertion, the queue SHALL empty immediately (asynchronously): count=0, we=0, pend_mask=0, pointers=0.
REQ-026 During reset, alu_ready and ld_ready SHALL be 0.
REQ-027 wr/wd SHALL read 0 while reset is asserted.
REQ-028 Reset mid-operation SHALL discard all queued entries; none SHALL reach the write port after rst deasserts.
REQ-029 Normal operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-030 Single ALU write: alu rd=5, wd=0xDEADBEEF at edge N -> during the following cycle we=1, wr=5, wd=0xDEADBEEF, pend_mask=0x20; by N+2, count=0 and pend_mask=0.
REQ-031 Dual push: alu rd=1/0x11 and ld rd=2/0x22 in the same cycle -> write port shows wr=1 then wr=2 on consecutive cycles; count peaks at 2.
REQ-032 x0 drop: alu rd=0, wd=0xFFFFFFFF accepted -> we stays 0, count stays 0, pend_mask stays 0.
REQ-033 Full/backpressure: with DEPTH=4 and count=3, both valid -> alu accepted, ld_ready=0, ld held; ld accepted on the next cycle; order is preserved.
REQ-034 Wrap-around: 10 back-to-back ALU writes rd=1..10 -> write-port sequence 1..10 with matching data and no gaps after the first.
REQ-035 Reset mid-flight: with 3 entries queued, pulse rst between edges -> count=0 and we=0 immediately; no queued rd is ever written afterwards.
